pipeline_hazard_sequencer: RTL and testbench
============================================

# pipeline_hazard_sequencer

Central stall/flush sequencer for the 5-stage RV32 pipeline. It arbitrates the decode-stage redirect request (branch/JAL/JALR resolution), load-use interlocks, and instruction/data memory wait states into one consistent set of stage stall/flush controls and a PC-select command. It holds redirects that arrive while fetch cannot accept them, and it keeps performance/fault counters. It sits beside the hazard/forwarding logic in the top-level datapath.

## Interface
- DMEM_TIMEOUT, 255: number of consecutive data-memory wait cycles after which `dmem_timeout` is set (1..65535).
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- redirect_valid  in  1  decode resolved a taken branch/jump this cycle.
- redirect_pc  in  32  target for `redirect_valid`.
- Rs1address, Rs2address  in  5 each  decode source registers.
- use_rs1D, use_rs2D  in  1 each  decode instruction actually reads rs1/rs2.
- branchD  in  1  decode instruction is a branch or JALR, so it compares operands in D.
- MemReadE, MemReadM  in  1 each  load in E / M.
- RdEAddress, RdMAddress  in  5 each  destination registers in E / M.
- mem_req_M  in  1  M stage issues a data-memory access.
- imem_ready, dmem_ready  in  1 each  memory completes this cycle.
- StallF, StallD, StallE, StallM  out  1 each  hold the stage register.
- FlushD, FlushE  out  1 each  load a bubble into the D or E register.
- pc_redirect_valid  out  1  PC mux selects `pc_redirect`.
- pc_redirect  out  32  redirect target.
- dmem_timeout  out  1  sticky fault flag.
- stall_cycles, redirect_count  out  32 each  performance counters.

## Operation
- States: RUN, DMEM_WAIT, REDIRECT_HOLD. Registers: `pend_pc[31:0]`, `wait_cnt[15:0]`, the counters, and `dmem_timeout`.
- Hazard terms, computed combinationally:
  - `lu = MemReadE & RdE!=0 & ((RdE==Rs1 & use_rs1D) | (RdE==Rs2 & use_rs2D))`
  - `bl = branchD & MemReadM & RdM!=0 & ((RdM==Rs1 & use_rs1D) | (RdM==Rs2 & use_rs2D))`
  - `hz = lu | bl`
- Priority in RUN, highest first:
  1. `mem_req_M & ~dmem_ready`: freeze. StallF=StallD=StallE=StallM=1, no flush, redirect ignored. Go to DMEM_WAIT.
  2. `hz`: StallF=StallD=1, FlushE=1, redirect ignored because the operands are not valid yet.
  3. `redirect_valid`: FlushD=1, pc_redirect_valid=1, pc_redirect=redirect_pc, `redirect_count`++. If imem_ready=0, StallF=1, latch `pend_pc<=redirect_pc`, and go to REDIRECT_HOLD.
  4. `~imem_ready`: StallF=1, FlushD=1 (a bubble advances into D).
  5. Otherwise all outputs are 0.
- DMEM_WAIT: freeze as in RUN item 1; `wait_cnt`++ (saturating). On dmem_ready=1, outputs are 0 that cycle (the pipe advances), `wait_cnt<=0`, go to RUN. When `wait_cnt` reaches DMEM_TIMEOUT, set `dmem_timeout`. It is cleared only by reset and the state does not change.
- REDIRECT_HOLD: pc_redirect_valid=1, pc_redirect=pend_pc, FlushD=1 every cycle. Hazard terms and redirect_valid are ignored because D holds a bubble. StallF=~imem_ready. Go to RUN when imem_ready=1.
- `redirect_count` increments once per accepted redirect, never while in HOLD.
- `stall_cycles` increments every cycle in which StallF=1.
- Both counters wrap modulo 2^32.
- pc_redirect is 0 whenever pc_redirect_valid=0.

## Timing
- Reset (async, immediate): state=RUN, pend_pc=0, wait_cnt=0, counters=0, dmem_timeout=0. All stall/flush and pc_redirect outputs are 0 while reset=1.
- Control outputs are Mealy (same-cycle combinational from state and inputs). Counters, pend_pc and dmem_timeout are registered, visible the cycle after the event.
- Redirect latency: PC takes the target at the first rising edge where imem_ready=1 (0 extra cycles if ready in the request cycle).
- Simultaneous events:
  - dmem wait + redirect: the redirect is dropped; decode re-asserts it after the freeze.
  - hz + redirect: stall wins.
  - imem not ready + redirect: goes to HOLD.
- A dmem_ready arriving in the same cycle as the timeout threshold clears `wait_cnt` and does not set the flag.
- Reset asserted mid-HOLD or mid-DMEM_WAIT discards the pending redirect and the wait immediately.

## Test plan
- Load x5 in E, decode `add x6,x5,x1` (use_rs1D=1): StallF=StallD=FlushE=1 for 1 cycle, stall_cycles=1 afterwards. Repeat with RdE=0: no stall.
- branchD with MemReadM, RdM=x7=Rs2: one cycle StallF/StallD/FlushE. The redirect_valid asserted in that cycle is ignored, and redirect_count is unchanged.
- redirect_valid, redirect_pc=0x0000_0100, imem_ready=0 for 3 cycles: REDIRECT_HOLD with pc_redirect=0x100, FlushD=1 and StallF=1 for 3 cycles. The PC loads 0x100 on the 4th edge, and redirect_count=1.
- mem_req_M with dmem_ready low for 4 cycles while redirect_valid pulses: all four stages stall for 4 cycles with no flush and no redirect, then RUN resumes.
- DMEM_TIMEOUT=3 with dmem_ready held low: dmem_timeout rises after the 3rd wait cycle and stays 1 after dmem_ready. Only reset clears it.
- Assert reset during REDIRECT_HOLD: all outputs are 0 immediately, and after release there is no redirect to the old pend_pc.

Source files
------------

// File: rtl/pipeline_hazard_sequencer.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: arbitrates dmem wait
// states, load-use interlocks, decode redirects and imem wait states.
module pipeline_hazard_sequencer #(
  parameter int unsigned DMEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic [4:0]  Rs1address,
  input  logic [4:0]  Rs2address,
  input  logic        use_rs1D,
  input  logic        use_rs2D,
  input  logic        branchD,
  input  logic        MemReadE,
  input  logic        MemReadM,
  input  logic [4:0]  RdEAddress,
  input  logic [4:0]  RdMAddress,
  input  logic        mem_req_M,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        pc_redirect_valid,
  output logic [31:0] pc_redirect,
  output logic        dmem_timeout,
  output logic [31:0] stall_cycles,
  output logic [31:0] redirect_count
);

  localparam logic [1:0] RUN           = 2'd0;
  localparam logic [1:0] DMEM_WAIT     = 2'd1;
  localparam logic [1:0] REDIRECT_HOLD = 2'd2;
  localparam logic [15:0] TIMEOUT_CNT  = 16'(DMEM_TIMEOUT);

  logic [1:0]  state, state_nxt;
  logic [31:0] pend_pc;
  logic [15:0] wait_cnt, wait_cnt_inc;
  logic        lu, bl, hz;
  logic        wait_cycle, accept_redirect, latch_pend;

  // Load in E feeding any D operand, or load in M feeding a D-stage compare.
  assign lu = MemReadE && (RdEAddress != 5'd0) &&
              (((RdEAddress == Rs1address) && use_rs1D) ||
               ((RdEAddress == Rs2address) && use_rs2D));
  assign bl = branchD && MemReadM && (RdMAddress != 5'd0) &&
              (((RdMAddress == Rs1address) && use_rs1D) ||
               ((RdMAddress == Rs2address) && use_rs2D));
  assign hz = lu || bl;

  assign wait_cnt_inc = (wait_cnt == 16'hFFFF) ? wait_cnt : wait_cnt + 16'd1;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_nxt         = state;
    StallF            = 1'b0;
    StallD            = 1'b0;
    StallE            = 1'b0;
    StallM            = 1'b0;
    FlushD            = 1'b0;
    FlushE            = 1'b0;
    pc_redirect_valid = 1'b0;
    pc_redirect       = 32'd0;
    wait_cycle        = 1'b0;
    accept_redirect   = 1'b0;
    latch_pend        = 1'b0;
    if (!reset) begin
      case (state)
        RUN: begin
          if (mem_req_M && !dmem_ready) begin
            {StallF, StallD, StallE, StallM} = 4'b1111;
            wait_cycle = 1'b1;
            state_nxt  = DMEM_WAIT;
          end else if (hz) begin
            // Operands are not valid yet, so any redirect this cycle is untrustworthy.
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
          end else if (redirect_valid) begin
            FlushD            = 1'b1;
            pc_redirect_valid = 1'b1;
            pc_redirect       = redirect_pc;
            accept_redirect   = 1'b1;
            if (!imem_ready) begin
              StallF     = 1'b1;
              latch_pend = 1'b1;
              state_nxt  = REDIRECT_HOLD;
            end
          end else if (!imem_ready) begin
            StallF = 1'b1;
            FlushD = 1'b1;
          end
        end
        DMEM_WAIT: begin
          if (dmem_ready) begin
            state_nxt = RUN;
          end else begin
            {StallF, StallD, StallE, StallM} = 4'b1111;
            wait_cycle = 1'b1;
          end
        end
        REDIRECT_HOLD: begin
          // D holds a bubble, so hazards and new redirects are irrelevant here.
          FlushD            = 1'b1;
          pc_redirect_valid = 1'b1;
          pc_redirect       = pend_pc;
          StallF            = !imem_ready;
          if (imem_ready) state_nxt = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= RUN;
      pend_pc        <= 32'd0;
      wait_cnt       <= 16'd0;
      dmem_timeout   <= 1'b0;
      stall_cycles   <= 32'd0;
      redirect_count <= 32'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_nxt;
      if (latch_pend) pend_pc <= redirect_pc;
      // wait_cnt counts wait cycles including the one that entered DMEM_WAIT.
      if (wait_cycle) begin
        wait_cnt <= wait_cnt_inc;
        if (wait_cnt_inc >= TIMEOUT_CNT) dmem_timeout <= 1'b1;
      end else if (state == DMEM_WAIT) begin
        wait_cnt <= 16'd0;
      end
      if (accept_redirect) redirect_count <= redirect_count + 32'd1;
      if (StallF) stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Self-checking bench for pipeline_hazard_sequencer: directed scenarios plus
// randomized traffic compared against a behavioural model of the sequencing rules.
module tb_pipeline_hazard_sequencer;

  localparam int unsigned TMO = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [4:0]  Rs1address, Rs2address, RdEAddress, RdMAddress;
  logic        use_rs1D, use_rs2D, branchD, MemReadE, MemReadM;
  logic        mem_req_M, imem_ready, dmem_ready;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, pc_redirect_valid;
  logic [31:0] pc_redirect, stall_cycles, redirect_count;
  logic        dmem_timeout;
  logic [6:0]  got_ctl;

  int checks = 0;
  int errors = 0;

  // Model: busy flags, pending target, wait length, fault flag, counters.
  bit          m_waiting, m_holding, m_timeout;
  int          m_wait;
  logic [31:0] m_pend, m_stall, m_redir;
  bit          n_waiting, n_holding, n_timeout;
  int          n_wait;
  logic [31:0] n_pend, n_stall, n_redir;
  logic [6:0]  e_ctl;
  logic [31:0] e_pc;

  pipeline_hazard_sequencer #(.DMEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .Rs1address(Rs1address), .Rs2address(Rs2address), .use_rs1D(use_rs1D), .use_rs2D(use_rs2D),
    .branchD(branchD), .MemReadE(MemReadE), .MemReadM(MemReadM),
    .RdEAddress(RdEAddress), .RdMAddress(RdMAddress), .mem_req_M(mem_req_M),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .pc_redirect_valid(pc_redirect_valid),
    .pc_redirect(pc_redirect), .dmem_timeout(dmem_timeout),
    .stall_cycles(stall_cycles), .redirect_count(redirect_count)
  );

  // Control bit order: StallF StallD StallE StallM FlushD FlushE pc_redirect_valid
  assign got_ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, pc_redirect_valid};

  always #5 clk = ~clk;

  function automatic bit reads(input int rd);
    return (rd != 0) && ((rd == int'(Rs1address) && use_rs1D) || (rd == int'(Rs2address) && use_rs2D));
  endfunction

  function automatic void model_eval();
    bit freeze_req, hazard;
    n_waiting = m_waiting; n_holding = m_holding; n_timeout = m_timeout;
    n_wait = m_wait; n_pend = m_pend; n_stall = m_stall; n_redir = m_redir;
    e_ctl = 7'd0; e_pc = 32'd0;
    freeze_req = mem_req_M && !dmem_ready;
    hazard = (MemReadE && reads(int'(RdEAddress))) || (branchD && MemReadM && reads(int'(RdMAddress)));
    if (reset) begin
      n_waiting = 0; n_holding = 0; n_timeout = 0; n_wait = 0;
      n_pend = 0; n_stall = 0; n_redir = 0;
    end else if (m_waiting) begin
      if (dmem_ready) begin n_waiting = 0; n_wait = 0; end
      else begin
        e_ctl = 7'b1111000;
        n_wait = (m_wait < 65535) ? m_wait + 1 : m_wait;
        if (n_wait >= int'(TMO)) n_timeout = 1;
      end
    end else if (m_holding) begin
      e_ctl = {!imem_ready, 3'b000, 1'b1, 1'b0, 1'b1};
      e_pc = m_pend;
      if (imem_ready) n_holding = 0;
    end else if (freeze_req) begin
      e_ctl = 7'b1111000;
      n_waiting = 1; n_wait = 1;
      if (1 >= int'(TMO)) n_timeout = 1;
    end else if (hazard) begin
      e_ctl = 7'b1100010;
    end else if (redirect_valid) begin
      e_ctl = {!imem_ready, 3'b000, 1'b1, 1'b0, 1'b1};
      e_pc = redirect_pc;
      n_redir = m_redir + 1;
      if (!imem_ready) begin n_holding = 1; n_pend = redirect_pc; end
    end else if (!imem_ready) begin
      e_ctl = 7'b1000100;
    end
    if (e_ctl[6]) n_stall = m_stall + 1;
  endfunction

  task automatic advance();
    model_eval();
    @(posedge clk);
    m_waiting = n_waiting; m_holding = n_holding; m_timeout = n_timeout;
    m_wait = n_wait; m_pend = n_pend; m_stall = n_stall; m_redir = n_redir;
    #1;
  endtask

  task automatic idle_inputs();
    redirect_valid = 0; redirect_pc = 32'd0;
    Rs1address = 0; Rs2address = 0; RdEAddress = 0; RdMAddress = 0;
    use_rs1D = 0; use_rs2D = 0; branchD = 0; MemReadE = 0; MemReadM = 0;
    mem_req_M = 0; imem_ready = 1; dmem_ready = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; redirect_valid = 1; redirect_pc = 32'hDEAD_BEEF; imem_ready = 0;
    #1;
    checks++;
    if (got_ctl !== 7'd0 || pc_redirect !== 32'd0) begin
      errors++; $display("FAIL reset_outputs got ctl=%b pc=%h want ctl=0000000 pc=0", got_ctl, pc_redirect);
    end
    advance();
    checks++;
    if (stall_cycles !== 32'd0 || redirect_count !== 32'd0 || dmem_timeout !== 1'b0) begin
      errors++; $display("FAIL reset_regs got stall=%0d redir=%0d tmo=%b want 0 0 0", stall_cycles, redirect_count, dmem_timeout);
    end
    idle_inputs();
    reset = 0;
    advance();
  endtask

  task automatic test_load_use();
    MemReadE = 1; RdEAddress = 5; Rs1address = 5; Rs2address = 1; use_rs1D = 1;
    #1;
    checks++;
    if (got_ctl !== 7'b1100010) begin
      errors++; $display("FAIL load_use_ctl got %b want 1100010", got_ctl);
    end
    advance();
    checks++;
    if (stall_cycles !== 32'd1) begin
      errors++; $display("FAIL load_use_count got %0d want 1", stall_cycles);
    end
    RdEAddress = 0; Rs1address = 0;
    #1;
    checks++;
    if (got_ctl !== 7'd0) begin
      errors++; $display("FAIL load_use_x0 got %b want 0000000", got_ctl);
    end
    advance();
    idle_inputs();
  endtask

  task automatic test_branch_load();
    logic [31:0] base;
    base = m_redir;
    branchD = 1; MemReadM = 1; RdMAddress = 7; Rs2address = 7; use_rs2D = 1;
    redirect_valid = 1; redirect_pc = $urandom;
    #1;
    checks++;
    if (got_ctl !== 7'b1100010 || pc_redirect !== 32'd0) begin
      errors++; $display("FAIL branch_load_ctl got ctl=%b pc=%h want 1100010 pc=0", got_ctl, pc_redirect);
    end
    advance();
    checks++;
    if (redirect_count !== base) begin
      errors++; $display("FAIL branch_load_redir got %0d want %0d", redirect_count, base);
    end
    branchD = 0;
    #1;
    checks++;
    if (got_ctl !== 7'b0000101 || pc_redirect !== redirect_pc) begin
      errors++; $display("FAIL redirect_fast got ctl=%b pc=%h want 0000101 pc=%h", got_ctl, pc_redirect, redirect_pc);
    end
    advance();
    checks++;
    if (redirect_count !== base + 32'd1) begin
      errors++; $display("FAIL redirect_fast_count got %0d want %0d", redirect_count, base + 32'd1);
    end
    idle_inputs();
  endtask

  task automatic test_redirect_hold();
    logic [31:0] base_r, base_s;
    base_r = m_redir; base_s = m_stall;
    redirect_valid = 1; redirect_pc = 32'h0000_0100; imem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) imem_ready = 1;
      #1;
      checks++;
      if (got_ctl !== {(i != 3), 6'b000101} || pc_redirect !== 32'h100) begin
        errors++; $display("FAIL hold_cycle%0d got ctl=%b pc=%h want %b pc=00000100", i, got_ctl, pc_redirect, {(i != 3), 6'b000101});
      end
      advance();
      // Later cycles offer a hazard and a new target, both of which HOLD ignores.
      redirect_valid = 0; redirect_pc = 32'h0000_0200;
      MemReadE = 1; RdEAddress = 3; Rs1address = 3; use_rs1D = 1;
    end
    idle_inputs();
    #1;
    checks++;
    if (got_ctl !== 7'd0 || redirect_count !== base_r + 32'd1 || stall_cycles !== base_s + 32'd3) begin
      errors++; $display("FAIL hold_exit got ctl=%b redir=%0d stall=%0d want 0000000 %0d %0d",
                         got_ctl, redirect_count, stall_cycles, base_r + 32'd1, base_s + 32'd3);
    end
    advance();
  endtask

  task automatic test_dmem_freeze();
    logic [31:0] base_r;
    base_r = m_redir;
    mem_req_M = 1; dmem_ready = 0; redirect_pc = 32'h0000_0400;
    for (int i = 0; i < 4; i++) begin
      redirect_valid = i[0];
      #1;
      checks++;
      if (got_ctl !== 7'b1111000 || pc_redirect !== 32'd0) begin
        errors++; $display("FAIL freeze_cycle%0d got ctl=%b pc=%h want 1111000 pc=0", i, got_ctl, pc_redirect);
      end
      advance();
      checks++;
      if (dmem_timeout !== (i >= 2)) begin
        errors++; $display("FAIL freeze_tmo%0d got %b want %b", i, dmem_timeout, (i >= 2));
      end
    end
    dmem_ready = 1; redirect_valid = 0;
    #1;
    checks++;
    if (got_ctl !== 7'd0) begin
      errors++; $display("FAIL freeze_release got %b want 0000000", got_ctl);
    end
    advance();
    mem_req_M = 0; redirect_valid = 1;
    #1;
    checks++;
    if (got_ctl !== 7'b0000101 || redirect_count !== base_r || dmem_timeout !== 1'b1) begin
      errors++; $display("FAIL freeze_resume got ctl=%b redir=%0d tmo=%b want 0000101 %0d 1", got_ctl, redirect_count, dmem_timeout, base_r);
    end
    advance();
    idle_inputs();
  endtask

  task automatic test_timeout();
    reset = 1; #1; advance(); reset = 0; advance();
    mem_req_M = 1; dmem_ready = 0;
    advance(); advance();
    dmem_ready = 1;
    advance();
    checks++;
    if (dmem_timeout !== 1'b0) begin
      errors++; $display("FAIL tmo_ready_at_threshold got %b want 0", dmem_timeout);
    end
    dmem_ready = 0;
    advance(); advance();
    checks++;
    if (dmem_timeout !== 1'b0) begin
      errors++; $display("FAIL tmo_count_cleared got %b want 0", dmem_timeout);
    end
    advance();
    checks++;
    if (dmem_timeout !== 1'b1) begin
      errors++; $display("FAIL tmo_third_wait got %b want 1", dmem_timeout);
    end
    dmem_ready = 1; mem_req_M = 0;
    advance(); advance();
    checks++;
    if (dmem_timeout !== 1'b1) begin
      errors++; $display("FAIL tmo_sticky got %b want 1", dmem_timeout);
    end
    reset = 1; #1;
    checks++;
    if (dmem_timeout !== 1'b0) begin
      errors++; $display("FAIL tmo_reset got %b want 0", dmem_timeout);
    end
    advance(); reset = 0; idle_inputs();
  endtask

  task automatic test_reset_mid_hold();
    redirect_valid = 1; redirect_pc = 32'h0000_ABC0; imem_ready = 0;
    advance();
    redirect_valid = 0;
    #2 reset = 1;
    #1;
    checks++;
    if (got_ctl !== 7'd0 || pc_redirect !== 32'd0 || redirect_count !== 32'd0) begin
      errors++; $display("FAIL reset_hold got ctl=%b pc=%h redir=%0d want 0000000 0 0", got_ctl, pc_redirect, redirect_count);
    end
    advance();
    reset = 0; imem_ready = 1;
    #1;
    checks++;
    if (got_ctl !== 7'd0 || pc_redirect !== 32'd0) begin
      errors++; $display("FAIL reset_hold_after got ctl=%b pc=%h want 0000000 0", got_ctl, pc_redirect);
    end
    advance();
  endtask

  task automatic test_random();
    int bad = 0;
    for (int n = 0; n < 600; n++) begin
      reset          = ($urandom_range(0, 99) == 0);
      redirect_valid = ($urandom_range(0, 2) == 0);
      redirect_pc    = $urandom;
      Rs1address = 5'($urandom_range(0, 3)); Rs2address = 5'($urandom_range(0, 3));
      RdEAddress = 5'($urandom_range(0, 3)); RdMAddress = 5'($urandom_range(0, 3));
      use_rs1D = 1'($urandom); use_rs2D = 1'($urandom); branchD = 1'($urandom);
      MemReadE = ($urandom_range(0, 3) == 0); MemReadM = ($urandom_range(0, 2) == 0);
      mem_req_M  = ($urandom_range(0, 3) == 0);
      imem_ready = ($urandom_range(0, 3) != 0);
      dmem_ready = ($urandom_range(0, 2) != 0);
      #1;
      model_eval();
      checks++;
      if (got_ctl !== e_ctl || pc_redirect !== e_pc) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL rand_out%0d got ctl=%b pc=%h want ctl=%b pc=%h", n, got_ctl, pc_redirect, e_ctl, e_pc);
      end
      advance();
      checks++;
      if (stall_cycles !== m_stall || redirect_count !== m_redir || dmem_timeout !== m_timeout) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL rand_regs%0d got stall=%0d redir=%0d tmo=%b want %0d %0d %b",
                               n, stall_cycles, redirect_count, dmem_timeout, m_stall, m_redir, m_timeout);
      end
    end
    reset = 0; idle_inputs();
  endtask

  initial begin
    m_waiting = 0; m_holding = 0; m_timeout = 0; m_wait = 0;
    m_pend = 0; m_stall = 0; m_redir = 0;
    test_reset();
    test_load_use();
    test_branch_load();
    test_redirect_hold();
    test_dmem_freeze();
    test_timeout();
    test_reset_mid_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
